instruction_loader: RTL and testbench

Boot-time writer for the CPU's instruction RAM. It takes a byte stream from the host link through a valid/ready handshake and parses a framed image: a 16-bit word count, then big-endian instruction words, then an XOR checksum. Each assembled word is written to consecutive word addresses starting at 0. The pipeline is held in reset until the image is fully loaded and verified.

---
 rtl/instruction_loader_if.sv | 23 ++
 rtl/instruction_loader.sv | 103 ++++++++++
 tb/tb_instruction_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Host byte stream plus instruction RAM write port and boot status of the instruction loader.
// The loader connects through the master modport; the host/RAM side uses the slave modport.
interface instruction_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/instruction_loader.sv
// Boot loader: parses a framed byte image (count, big-endian words, XOR checksum) into
// instruction RAM and keeps the CPU in reset until the image has been verified.
//
// state | meaning
// HDR0  | waiting for word count high byte
// HDR1  | waiting for word count low byte
// DATA  | assembling words and writing them to RAM
// CSUM  | waiting for checksum byte
// DONE  | image verified, CPU released (terminal)
// ERROR | image rejected (terminal)
module instruction_loader #(
    parameter int DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    instruction_loader_if.master bus
);
    localparam logic [2:0] S_HDR0  = 3'd0;
    localparam logic [2:0] S_HDR1  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]  state;
    logic [7:0]  cnt_hi;
    logic [15:0] word_total;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;
    logic [7:0]  csum;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        ready;
    logic        accept;
    logic [16:0] count_in;

    // Gated by reset so the host sees no ready while the loader is held.
    assign ready = !reset && (state == S_HDR0 || state == S_HDR1 ||
                              state == S_DATA || state == S_CSUM);
    assign accept   = bus.in_valid && ready;
    assign count_in = {1'b0, cnt_hi, bus.in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_HDR0;
            cnt_hi      <= 8'd0;
            word_total  <= 16'd0;
            word_cnt    <= 16'd0;
            byte_cnt    <= 2'd0;
            shreg       <= 24'd0;
            csum        <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept) begin
                case (state)
                    S_HDR0: begin
                        cnt_hi <= bus.in_data;
                        state  <= S_HDR1;
                    end
                    S_HDR1: begin
                        word_total <= count_in[15:0];
                        if (count_in > 17'(DEPTH))
                            state <= S_ERROR;
                        else if (count_in == 17'd0)
                            state <= S_CSUM;
                        else
                            state <= S_DATA;
                    end
                    S_DATA: begin
                        csum     <= csum ^ bus.in_data;
                        shreg    <= {shreg[15:0], bus.in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata_q <= {shreg, bus.in_data};
                            mem_addr_q  <= {14'd0, word_cnt, 2'b00};
                            mem_we_q    <= 1'b1;
                            word_cnt    <= word_cnt + 16'd1;
                            if (word_cnt == word_total - 16'd1)
                                state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        state <= (bus.in_data == csum) ? S_DONE : S_ERROR;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_reset = (state != S_DONE);
    assign bus.done      = (state == S_DONE);
    assign bus.error     = (state == S_ERROR);
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: expected RAM writes are queued as words are
// streamed and matched against mem_we pulses; status flags are checked after each frame.
module tb_instruction_loader;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [63:0] sb[$];
    logic        prev_we;
    logic [31:0] img [0:1];

    instruction_loader_if bus ();

    instruction_loader #(.DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest queued write and last one cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            chk("we_pulse_width", {31'd0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                chk("we_expected", 32'(sb.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("mem_addr", bus.mem_addr, e[63:32]);
                chk("mem_wdata", bus.mem_wdata, e[31:0]);
            end
        end
        prev_we = (bus.mem_we === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input int n, input logic [7:0] csum_flip, input int gap);
        logic [7:0]  x;
        logic [15:0] cnt;
        logic [31:0] w;
        x   = 8'd0;
        cnt = 16'(n);
        send_byte(cnt[15:8], gap);
        send_byte(cnt[7:0], gap);
        for (int k = 0; k < n; k++) begin
            w = img[k];
            sb.push_back({32'(4 * k), w});
            for (int j = 3; j >= 0; j--) begin
                x = x ^ w[8*j +: 8];
                send_byte(w[8*j +: 8], gap);
            end
        end
        send_byte(x ^ csum_flip, gap);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c, input logic r);
        chk({tag, "_done"},      {31'd0, bus.done},      {31'd0, d});
        chk({tag, "_error"},     {31'd0, bus.error},     {31'd0, e});
        chk({tag, "_cpu_reset"}, {31'd0, bus.cpu_reset}, {31'd0, c});
        chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  {31'd0, r});
        chk({tag, "_sb_empty"},  32'(sb.size()),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_we  = 1'b0;
        img[0]   = 32'h2004_0003;
        img[1]   = 32'h0C00_0003;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("rst_done",      {31'd0, bus.done},      32'd0);
        chk("rst_error",     {31'd0, bus.error},     32'd0);
        chk("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
        chk("rst_mem_addr",  bus.mem_addr,           32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,          32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);

        // Valid load, back to back
        load(2, 8'h00, 0);
        check_status("valid", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("valid_hold_addr",  bus.mem_addr,  32'h0000_0004);
        chk("valid_hold_wdata", bus.mem_wdata, 32'h0C00_0003);

        // Empty image
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("empty_done_early", {31'd0, bus.done}, 32'd0);
        send_byte(8'h00, 0);
        check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

        // Bad checksum (0x29 instead of 0x28), then extra bytes are ignored
        do_reset();
        load(2, 8'h01, 0);
        check_status("badcs", 1'b0, 1'b1, 1'b1, 1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        check_status("badcs_extra", 1'b0, 1'b1, 1'b1, 1'b0);

        // Oversize count 257
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Throttled input
        do_reset();
        load(2, 8'h00, 3);
        check_status("throttle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-load after 6 bytes, then replay
        do_reset();
        sb.push_back({32'd0, img[0]});
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_mem_we",    {31'd0, bus.mem_we},    32'd0);
        chk("midrst_mem_addr",  bus.mem_addr,           32'd0);
        chk("midrst_mem_wdata", bus.mem_wdata,          32'd0);
        chk("midrst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("midrst_sb_empty",  32'(sb.size()),         32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load(2, 8'h00, 0);
        check_status("replay", 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
